// File: rtl/digit_serial_adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM state encoding and
// helpers that derive the digit count and digit-index width from the parameters.
package digit_serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int ndig_of(input int width, input int digit);
        return width / digit;
    endfunction

    // A single-digit configuration still needs a 1-bit index register.
    function automatic int idx_width(input int width, input int digit);
        int w;
        w = $clog2(width / digit);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/digit_serial_adder_digit.sv
// DIGIT-bit ripple-carry adder built from 1-bit full-adder cells; also reports
// the carry into its top bit so the caller can derive signed overflow.
module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [DIGIT:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign co    = c[DIGIT];
    assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial add/subtract unit: latches one operand set, processes DIGIT bits
// per clock through a single digit adder, then holds the result until consumed.
module digit_serial_adder
    import digit_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NDIG = ndig_of(WIDTH, DIGIT);
    localparam int IW   = idx_width(WIDTH, DIGIT);

    if ((WIDTH % DIGIT) != 0 || DIGIT < 2) begin : g_bad_params
        $error("digit_serial_adder: WIDTH must be a multiple of DIGIT and DIGIT >= 2");
    end

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; valid never depends on ready, and payload is stable while valid.
    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [IW-1:0]    idx;
    logic             last;

    logic [DIGIT-1:0] d_sum;
    logic             d_co;
    logic             d_cmsb;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN);
    assign last      = (idx == IW'(NDIG - 1));

    // Operands shift down one digit per RUN edge, so the adder always sees bit 0.
    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .x     (a_sh[DIGIT-1:0]),
        .y     (b_sh[DIGIT-1:0]),
        .ci    (carry),
        .s     (d_sum),
        .co    (d_co),
        .c_msb (d_cmsb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid)  next_state = RUN;
            RUN:     if (last)      next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default:                next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction is a + ~b + 1, with a borrow-in cancelling the +1.
                        a_sh  <= a;
                        b_sh  <= b ^ {WIDTH{sub}};
                        carry <= cin ^ sub;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    sum[int'(idx)*DIGIT +: DIGIT] <= d_sum;
                    carry <= d_co;
                    a_sh  <= a_sh >> DIGIT;
                    b_sh  <= b_sh >> DIGIT;
                    if (last) begin
                        cout <= d_co;
                        ovf  <= d_co ^ d_cmsb;
                        idx  <= '0;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Randomized and directed bench for digit_serial_adder (WIDTH=16, DIGIT=4)
// against an integer-arithmetic reference model.
module tb_digit_serial_adder;

    localparam int WIDTH = 16;
    localparam int DIGIT = 4;
    localparam int NDIG  = WIDTH / DIGIT;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;

    int n_pass;
    int n_total;
    logic [17:0] exp_q[$];

    digit_serial_adder #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // Returns {cout, ovf, sum} from plain integer arithmetic.
    function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic mcin, input logic msub);
        int ua, ub, sa, sb, ci, res, sres;
        logic c, v;
        ua = int'(ma);
        ub = int'(mb);
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        ci = int'(mcin);
        if (msub) begin
            res  = ua - ub - ci;
            sres = sa - sb - ci;
            c    = (ua >= ub + ci);
        end else begin
            res  = ua + ub + ci;
            sres = sa + sb + ci;
            c    = (res > 65535);
        end
        v = (sres > 32767) || (sres < -32768);
        return {c, v, res[15:0]};
    endfunction

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_in,
                          input logic tcin, input logic tsub, input int hold);
        logic [17:0] e;
        int lat;
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        a        = ta;
        b        = tb_in;
        cin      = tcin;
        sub      = tsub;
        in_valid = 1'b1;
        exp_q.push_back(model(ta, tb_in, tcin, tsub));
        @(negedge clk);
        in_valid = 1'b0;
        check("busy_run", 32'(busy), 32'd1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            a   = 16'($urandom);
            b   = 16'($urandom);
            cin = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'(NDIG));
        e = exp_q.pop_front();
        check("sum", 32'(sum), 32'(e[15:0]));
        check("cout", 32'(cout), 32'(e[17]));
        check("ovf", 32'(ovf), 32'(e[16]));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("hold_result", 32'({cout, ovf, sum}), 32'(e));
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        in_valid  = (hold > 0);
        @(negedge clk);
        out_ready = 1'b0;
        check("handoff_in_ready", 32'(in_ready), 32'd1);
        check("handoff_out_valid", 32'(out_valid), 32'd0);
        check("handoff_no_accept", 32'(busy), 32'd0);
        in_valid = 1'b0;
    endtask

    initial begin
        bit seen_valid;
        n_pass    = 0;
        n_total   = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 5);
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0);
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0);
        run_op(16'h8000, 16'h8000, 1'b0, 1'b0, 0);
        run_op(16'h0000, 16'h0000, 1'b1, 1'b1, 0);
        for (int k = 0; k < 20; k++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
        end

        // Abort an operation after two RUN edges.
        @(negedge clk);
        a        = 16'hABCD;
        b        = 16'h1111;
        cin      = 1'b0;
        sub      = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1'b1;
        end
        check("abort_no_out_valid", 32'(seen_valid), 32'd0);
        check("abort_idle", 32'(in_ready), 32'd1);
        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
